// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// State encoding, baud divider and oversample midpoint.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT
   } rx_state_e;

   // Truncated divide, never below 1 so the tick always advances.
   function automatic int unsigned baud_div(
      input int unsigned clk_hz,
      input int unsigned baud,
      input int unsigned os
   );
      int unsigned d;
      d = clk_hz / (baud * os);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic int unsigned os_mid(input int unsigned os);
      return os / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks.
// Held at zero while restart_i is high so ticks align to the start edge.
module uart_baud_gen #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_o = 1'b0;
      if (restart_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d  = '0;
         tick_o = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: rx synchroniser, frame FSM with
// mid-bit sampling, and a registered valid/ready output stage.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned OSW = $clog2(OVERSAMPLE);
   localparam int unsigned BCW = $clog2(DATA_BITS + 1);
   localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
   localparam logic [OSW-1:0] OS_MID   = OSW'(os_mid(OVERSAMPLE));
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

   rx_state_e            state_q, state_d;
   logic [1:0]           sync_q;
   logic                 rx_s;
   logic                 tick;
   logic [OSW-1:0]       os_q, os_d;
   logic [BCW-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 pen_q, pen_d;
   logic                 podd_q, podd_d;
   logic                 perr_q, perr_d;
   logic                 deliver;
   logic                 stop_bad;

   logic [DATA_BITS-1:0] dout_q;
   logic                 valid_q;
   logic                 operr_q;
   logic                 ferr_q;
   logic                 ovr_q;

   assign rx_s = sync_q[1];

   uart_baud_gen #(
      .DIV (DIV)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .restart_i (state_q == S_IDLE),
      .tick_o    (tick)
   );

   always_comb begin
      state_d  = state_q;
      os_d     = os_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      pen_d    = pen_q;
      podd_d   = podd_q;
      perr_d   = perr_q;
      deliver  = 1'b0;
      stop_bad = 1'b0;
      if (tick) os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
      unique case (state_q)
         S_IDLE: begin
            os_d = '0;
            if (!rx_s) begin
               state_d = S_START;
               pen_d   = parity_en;
               podd_d  = parity_odd;
               perr_d  = 1'b0;
            end
         end
         S_START: begin
            if (tick && os_q == OS_MID) begin
               os_d  = '0;
               bit_d = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick && os_q == OS_LAST) begin
               sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_LAST) state_d = pen_q ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (tick && os_q == OS_LAST) begin
               perr_d  = ((^sh_q) ^ rx_s) != podd_q;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick && os_q == OS_LAST) begin
               deliver  = 1'b1;
               stop_bad = !rx_s;
               state_d  = rx_s ? S_IDLE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sync_q  <= 2'b11;
         os_q    <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         pen_q   <= 1'b0;
         podd_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], rx};
         os_q    <= os_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         pen_q   <= pen_d;
         podd_q  <= podd_d;
         perr_q  <= perr_d;
      end
   end

   // A full, unaccepted output drops the new frame and flags overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
         operr_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         if (deliver) begin
            if (valid_q && !data_ready) begin
               ovr_q <= 1'b1;
            end else begin
               dout_q  <= sh_q;
               operr_q <= perr_q;
               ferr_q  <= stop_bad;
               valid_q <= 1'b1;
            end
         end else if (valid_q && data_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign parity_err = operr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames driven bit by bit,
// results checked against a frame-level reference model.
module tb_uart_rx_ctrl;

   localparam int BIT_CLK = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       parity_en;
   logic       parity_odd;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int valid_cyc = 0;
   int ovr_cnt  = 0;
   logic [9:0] got_q[$];

   always #5 clk = ~clk;

   uart_rx_ctrl #(
      .CLK_FREQ   (3_200_000),
      .BAUD       (100_000),
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid && data_ready)
            got_q.push_back({frame_err, parity_err, data_out});
         if (data_valid) valid_cyc++;
         if (overrun) ovr_cnt++;
      end
   end

   // Expected {frame_err, parity_err, byte} for one frame.
   function automatic logic [9:0] model(
      input logic [7:0] d,
      input logic pen, input logic podd,
      input logic pbit, input logic stop
   );
      int ones;
      logic perr;
      ones = $countones(d) + int'(pbit);
      perr = pen ? ((ones % 2) != int'(podd)) : 1'b0;
      return {~stop, perr, d};
   endfunction

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(
      input logic [7:0] d, input logic pen,
      input logic pbit, input logic stop
   );
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pen) drive_bit(pbit);
      drive_bit(stop);
   endtask

   task automatic get_item(output logic [9:0] it);
      it = 'x;
      for (int n = 0; n < 80 && got_q.size() == 0; n++) begin
         @(posedge clk);
         #1;
      end
      if (got_q.size() > 0) it = got_q.pop_front();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx = 1'b1;
      parity_en = 1'b0;
      parity_odd = 1'b0;
      data_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset valid got=%b exp=0", data_valid); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset data got=%h exp=00", data_out); end
      checks++; if ({parity_err, frame_err} !== 2'b00) begin failures++; $display("FAIL reset errs got=%b exp=00", {parity_err, frame_err}); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset overrun got=%b exp=0", overrun); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
      rst = 1'b0;
      drive_bit(1'b1);
   endtask

   task automatic test_8n1;
      logic [9:0] it, e;
      int v0;
      v0 = valid_cyc;
      e = model(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      get_item(it);
      checks++; if (it !== e) begin failures++; $display("FAIL 8n1 item got=%h exp=%h", it, e); end
      checks++; if (valid_cyc - v0 !== 1) begin failures++; $display("FAIL 8n1 valid_len got=%0d exp=1", valid_cyc - v0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL 8n1 busy got=%b exp=0", busy); end
   endtask

   task automatic test_glitch;
      logic [9:0] it, e;
      int v0;
      v0 = valid_cyc;
      rx = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch busy got=%b exp=0", busy); end
      checks++; if (valid_cyc !== v0) begin failures++; $display("FAIL glitch valid got=%0d exp=%0d", valid_cyc, v0); end
      drive_bit(1'b1);
      e = model(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      get_item(it);
      checks++; if (it !== e) begin failures++; $display("FAIL glitch next got=%h exp=%h", it, e); end
   endtask

   task automatic test_parity;
      logic [9:0] it, e;
      parity_en = 1'b1;
      parity_odd = 1'b1;
      for (int p = 0; p < 2; p++) begin
         e = model(8'h03, 1'b1, 1'b1, p[0], 1'b1);
         send_frame(8'h03, 1'b1, p[0], 1'b1);
         get_item(it);
         checks++; if (it !== e) begin failures++; $display("FAIL parity pbit=%0d got=%h exp=%h", p, it, e); end
      end
      parity_en = 1'b0;
      parity_odd = 1'b0;
      drive_bit(1'b1);
   endtask

   task automatic test_frame_err;
      logic [9:0] it, e;
      int v0;
      v0 = valid_cyc;
      e = model(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      get_item(it);
      checks++; if (it !== e) begin failures++; $display("FAIL ferr item got=%h exp=%h", it, e); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr hold_busy got=%b exp=1", busy); end
      checks++; if (valid_cyc - v0 !== 1 || got_q.size() !== 0) begin failures++; $display("FAIL ferr extra_frames valid_cycles=%0d exp=1", valid_cyc - v0); end
      rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr release_busy got=%b exp=0", busy); end
      drive_bit(1'b1);
   endtask

   task automatic test_overrun;
      logic [9:0] it;
      int o0;
      o0 = ovr_cnt;
      data_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL ovr valid got=%b exp=1", data_valid); end
      checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL ovr data got=%h exp=11", data_out); end
      checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL ovr pulse_cycles got=%0d exp=1", ovr_cnt - o0); end
      data_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL ovr drop got=%b exp=0", data_valid); end
      get_item(it);
      checks++; if (it[7:0] !== 8'h11) begin failures++; $display("FAIL ovr accepted got=%h exp=11", it[7:0]); end
   endtask

   task automatic test_rst_mid;
      logic [9:0] it, e;
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      repeat (16) @(posedge clk);
      #1;
      rst = 1'b1;
      rx = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid busy got=%b exp=0", busy); end
      checks++; if (data_out !== 8'h00 || data_valid !== 1'b0) begin failures++; $display("FAIL rstmid out got=%h/%b exp=00/0", data_out, data_valid); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      drive_bit(1'b1);
      checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rstmid partial got=%0d exp=0", got_q.size()); end
      e = model(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      get_item(it);
      checks++; if (it !== e) begin failures++; $display("FAIL rstmid next got=%h exp=%h", it, e); end
   endtask

   task automatic test_random;
      logic [9:0] it, e;
      logic [7:0] d;
      logic pen, podd, pbit, stop;
      for (int k = 0; k < 10; k++) begin
         d = 8'($urandom);
         pen = 1'($urandom);
         podd = 1'($urandom);
         pbit = 1'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         parity_en = pen;
         parity_odd = podd;
         e = model(d, pen, podd, pbit, stop);
         send_frame(d, pen, pbit, stop);
         if (!stop) drive_bit(1'b1);
         get_item(it);
         checks++; if (it !== e) begin failures++; $display("FAIL random k=%0d got=%h exp=%h", k, it, e); end
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_glitch();
      test_parity();
      test_frame_err();
      test_overrun();
      test_rst_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
